// File: rtl/aes128_iter_11cc.sv
// aes128_iter_11cc: iterative AES-128 encryptor, one round per clock with on-the-fly key expansion
module aes128_iter_11cc (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] g_init,
  input  logic [127:0] e_init,
  output logic [127:0] o
);
  logic [127:0] r_state, r_rkey;
  logic [7:0]   r_rcon;
  logic [3:0]   r_rnd;
  logic [127:0] w_sb, w_sr, w_mc, w_nk;
  logic [31:0]  w_kw, w_w4, w_w5, w_w6, w_w7;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      r = r ^ (b[k] ? x : 8'h00);
      x = xt(x);
    end
    return r;
  endfunction

  // inverse as a^254 (maps 0 to 0), then the FIPS affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, v;
    p = a;
    v = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gm(p, p);
      v = gm(v, p);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  genvar i;
  for (i = 0; i < 16; i++) begin : g_sb
    assign w_sb[8*i +: 8] = sbox(r_state[8*i +: 8]);
    assign w_sr[8*i +: 8] = w_sb[8*(4*(((i/4) + (i%4)) % 4) + (i%4)) +: 8];
  end

  for (i = 0; i < 4; i++) begin : g_mc
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_sr[32*i +: 8];
    assign w_a1 = w_sr[32*i+8 +: 8];
    assign w_a2 = w_sr[32*i+16 +: 8];
    assign w_a3 = w_sr[32*i+24 +: 8];
    assign w_mc[32*i +: 32] = {xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3),
                               w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3,
                               w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3,
                               xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3};
  end

  // SubWord(RotWord(w3)) with rcon folded into byte 0
  assign w_kw = {sbox(r_rkey[103:96]), sbox(r_rkey[127:120]), sbox(r_rkey[119:112]),
                 sbox(r_rkey[111:104])} ^ {24'h0, r_rcon};
  assign w_w4 = r_rkey[31:0] ^ w_kw;
  assign w_w5 = r_rkey[63:32] ^ w_w4;
  assign w_w6 = r_rkey[95:64] ^ w_w5;
  assign w_w7 = r_rkey[127:96] ^ w_w6;
  assign w_nk = {w_w7, w_w6, w_w5, w_w4};
  assign o = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= e_init ^ g_init;
      r_rkey  <= g_init;
      r_rcon  <= 8'h01;
      r_rnd   <= 4'd1;
    end else if (r_rnd >= 4'd1 && r_rnd <= 4'd10) begin
      r_state <= (r_rnd == 4'd10 ? w_sr : w_mc) ^ w_nk;
      r_rkey  <= w_nk;
      r_rcon  <= xt(r_rcon);
      r_rnd   <= r_rnd + 4'd1;
    end
  end
endmodule

// File: tb/tb_aes128_iter_11cc.sv
// tb_aes128_iter_11cc: directed and random checks of the AES-128 core against a byte-array reference model
module tb_aes128_iter_11cc;
  logic         clk, rst;
  logic [127:0] g_init, e_init, o;
  logic [7:0]   sb [256];
  int           nv = 0, nerr = 0;

  aes128_iter_11cc dut (.clk(clk), .rst(rst), .g_init(g_init), .e_init(e_init), .o(o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mx(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) r = r ^ a;
      a = mx(a);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = h[8*(15-k) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] ek [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tw [4];
    logic [7:0] m [4];
    logic [7:0] rc;
    logic [127:0] r;
    m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int k = 0; k < 16; k++) begin
      ek[k] = key[8*k +: 8];
      s[k] = pt[8*k +: 8] ^ ek[k];
    end
    rc = 8'h01;
    for (int k = 16; k < 176; k += 4) begin
      for (int j = 0; j < 4; j++) tw[j] = ek[k-4+j];
      if (k % 16 == 0) begin
        tw = '{sb[ek[k-3]], sb[ek[k-2]], sb[ek[k-1]], sb[ek[k-4]]};
        tw[0] = tw[0] ^ rc;
        rc = mx(rc);
      end
      for (int j = 0; j < 4; j++) ek[k+j] = ek[k-16+j] ^ tw[j];
    end
    for (int rd = 1; rd <= 10; rd++) begin
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[4*col+row] = sb[s[4*((col+row)%4)+row]];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++) begin
          s[4*col+row] = ek[16*rd+4*col+row];
          if (rd < 10)
            for (int k = 0; k < 4; k++) s[4*col+row] = s[4*col+row] ^ gmul(m[(k-row+4)%4], t[4*col+k]);
          else
            s[4*col+row] = s[4*col+row] ^ t[4*col+row];
        end
    end
    for (int k = 0; k < 16; k++) r[8*k +: 8] = s[k];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] p);
    g_init = k;
    e_init = p;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [127:0] exp);
    nv++;
    assert (o === exp) else begin
      nerr++;
      $error("FAIL %s: o=%h expected %h", tag, o, exp);
    end
  endtask

  initial begin
    logic [127:0] c1k, c1p, k, p, exp;
    logic [7:0] q, pp;
    pp = 8'h01;
    q = 8'h01;
    do begin
      pp = pp ^ {pp[6:0], 1'b0} ^ (pp[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sb[pp] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (pp != 8'h01);
    sb[0] = 8'h63;
    rst = 1'b1;
    g_init = '0;
    e_init = '0;
    step();
    c1k = fips(128'h000102030405060708090a0b0c0d0e0f);
    c1p = fips(128'h00112233445566778899aabbccddeeff);
    load(c1k, c1p);
    chk("c1_reset", c1k ^ c1p);
    repeat (10) step();
    chk("c1_known", fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
    chk("c1_model", aes_ref(c1k, c1p));
    load(fips(128'he4dc18adf3d05ec9e4dcc41acb990007), fips(128'h4072da1240f930f7d3c8cf8b9322042e));
    repeat (11) step();
    chk("v2_known", fips(128'hd225406f484809186cb5d86be4098445));
    load('0, '0);
    chk("zero_reset", '0);
    repeat (10) step();
    chk("zero_known", fips(128'h66e94bd4ef8a2c3b884cfa59ca342b2e));
    repeat (20) step();
    chk("zero_hold", fips(128'h66e94bd4ef8a2c3b884cfa59ca342b2e));
    load(rnd128(), rnd128());
    repeat (4) step();
    load(c1k, c1p);
    chk("mid_reset_load", c1k ^ c1p);
    repeat (10) step();
    chk("mid_reset_c1", fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
    k = rnd128();
    p = rnd128();
    load(k, p);
    for (int n = 0; n < 10; n++) begin
      g_init = rnd128();
      e_init = rnd128();
      step();
    end
    chk("inputs_ignored", aes_ref(k, p));
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      g_init = rnd128();
      e_init = rnd128();
      step();
    end
    chk("held_reset", g_init ^ e_init);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      k = rnd128();
      p = rnd128();
      exp = aes_ref(k, p);
      load(k, p);
      chk("rand_reset", k ^ p);
      repeat (10) step();
      chk("rand_final", exp);
      step();
      chk("rand_hold", exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
